// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Two-requester round-robin arbiter owning the 2:1 mux select,
//            with bounded burst length per grant and valid/ready output.
// Revision : 1.0
// ============================================================================
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_gnt,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } state_t;

    localparam logic [3:0] c_hold_last = 4'(MAX_HOLD - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_hold_cnt;
    logic [3:0] w_hold_nxt;
    logic       r_last_a;       // 1: A held the most recent grant
    logic       w_last_a_nxt;
    logic       r_a_gnt;
    logic       r_b_gnt;
    logic       r_sel;
    logic       r_busy;
    logic       w_beat;

    assign out_valid = (r_a_gnt & a_req) | (r_b_gnt & b_req);
    assign out_data  = r_a_gnt ? a_data : (r_b_gnt ? b_data : '0);
    assign w_beat    = out_valid & out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_last_a_nxt = r_last_a;
        case (r_state)
            ST_IDLE: begin
                // On a tie the side that did not hold the last grant wins
                if (a_req && (!b_req || !r_last_a)) begin
                    w_state_nxt  = ST_GRANT_A;
                    w_hold_nxt   = 4'd0;
                    w_last_a_nxt = 1'b1;
                end else if (b_req) begin
                    w_state_nxt  = ST_GRANT_B;
                    w_hold_nxt   = 4'd0;
                    w_last_a_nxt = 1'b0;
                end
            end
            ST_GRANT_A: begin
                if (!a_req) begin
                    w_hold_nxt  = 4'd0;
                    w_state_nxt = b_req ? ST_GRANT_B : ST_IDLE;
                    if (b_req) w_last_a_nxt = 1'b0;
                end else if (w_beat) begin
                    if (r_hold_cnt == c_hold_last) begin
                        w_hold_nxt = 4'd0;
                        if (b_req) begin
                            w_state_nxt  = ST_GRANT_B;
                            w_last_a_nxt = 1'b0;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt + 4'd1;
                    end
                end
            end
            ST_GRANT_B: begin
                if (!b_req) begin
                    w_hold_nxt  = 4'd0;
                    w_state_nxt = a_req ? ST_GRANT_A : ST_IDLE;
                    if (a_req) w_last_a_nxt = 1'b1;
                end else if (w_beat) begin
                    if (r_hold_cnt == c_hold_last) begin
                        w_hold_nxt = 4'd0;
                        if (a_req) begin
                            w_state_nxt  = ST_GRANT_A;
                            w_last_a_nxt = 1'b1;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_last_a   <= 1'b0;
            r_a_gnt    <= 1'b0;
            r_b_gnt    <= 1'b0;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last_a   <= w_last_a_nxt;
            r_a_gnt    <= (w_state_nxt == ST_GRANT_A);
            r_b_gnt    <= (w_state_nxt == ST_GRANT_B);
            r_sel      <= (w_state_nxt == ST_GRANT_A);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign a_gnt = r_a_gnt;
    assign b_gnt = r_b_gnt;
    assign sel   = r_sel;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Scenario bench for mux_rr_arbiter with a beat scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_req, b_req, out_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_gnt, b_gnt, sel, out_valid, busy;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] sb_q[$];    // {source is A, data}
    logic [WIDTH:0] sb_exp;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_data(b_data), .b_gnt(b_gnt),
        .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; beats are consumed here just before
    // the rising edge that accepts them.
    always @(negedge clk) begin
        #2;
        checks++;
        if ((a_gnt & b_gnt) !== 1'b0) begin
            errors++;
            $display("FAIL mutex a_gnt=%b b_gnt=%b required not both high", a_gnt, b_gnt);
        end
        checks++;
        if (sel !== a_gnt || busy !== (a_gnt | b_gnt)) begin
            errors++;
            $display("FAIL decode sel=%b busy=%b a_gnt=%b b_gnt=%b", sel, busy, a_gnt, b_gnt);
        end
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat sel=%b data=%h required no beat", sel, out_data);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({sel, out_data} !== sb_exp) begin
                    errors++;
                    $display("FAIL beat got sel/data=%h required %h", {sel, out_data}, sb_exp);
                end
            end
        end
    end

    task automatic drive(input logic ar, input logic br, input logic [WIDTH-1:0] ad,
                         input logic [WIDTH-1:0] bd, input logic rdy);
        a_req = ar; b_req = br; a_data = ad; b_data = bd; out_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
        #1;
        checks++;
        if ({a_gnt, b_gnt, out_valid, sel, busy, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b%b v=%b sel=%b busy=%b data=%h required all 0",
                     a_gnt, b_gnt, out_valid, sel, busy, out_data);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
        #1;
        checks++;
        if (a_gnt !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency a_gnt=%b valid=%b required 0 0", a_gnt, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
            sb_q.push_back({1'b1, 8'h5A});
            #1;
            checks++;
            if (a_gnt !== 1'b1 || sel !== 1'b1 || out_data !== 8'h5A || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_beat%0d a_gnt=%b sel=%b data=%h required 1 1 5a", i, a_gnt, sel, out_data);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop valid=%b required 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b required 0", busy);
        end
    endtask

    // Last grant was A, so a simultaneous request pair must go to B.
    task automatic test_tie();
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle busy=%b required 0", busy);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        #1;
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || out_data !== 8'h22 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL tie_grant a_gnt=%b b_gnt=%b data=%h required 0 1 22", a_gnt, b_gnt, out_data);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle_end busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] ad, bd;
        logic             exp_a;
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hA0, 8'hB0, 1'b1);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle busy=%b required 0", busy);
        end
        for (int i = 1; i <= 3 * MAX_HOLD; i++) begin
            @(negedge clk);
            ad    = 8'hA0 + 8'(i);
            bd    = 8'hB0 + 8'(i);
            exp_a = (((i - 1) / MAX_HOLD) % 2) == 0;
            drive(1'b1, 1'b1, ad, bd, 1'b1);
            sb_q.push_back({exp_a, exp_a ? ad : bd});
            #1;
            checks++;
            if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
                errors++;
                $display("FAIL rr_cycle%0d a_gnt=%b b_gnt=%b required %b %b", i, a_gnt, b_gnt, exp_a, !exp_a);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        checks++;
        if (b_gnt !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_handover b_gnt=%b valid=%b required 1 0", b_gnt, out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_end busy=%b required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hC0, 8'hD0, 1'b1);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i <= 2 || i == 8 || i == 9) begin
                drive(1'b1, 1'b1, 8'hC0 + 8'(i), 8'hD0 + 8'(i), 1'b1);
                sb_q.push_back({1'b1, 8'hC0 + 8'(i)});
            end else if (i <= 7) begin
                drive(1'b1, 1'b1, 8'hC0 + 8'(i), 8'hD0 + 8'(i), 1'b0);
            end else if (i == 10) begin
                drive(1'b1, 1'b1, 8'hC0 + 8'(i), 8'hD0 + 8'(i), 1'b1);
                sb_q.push_back({1'b0, 8'hD0 + 8'(i)});
            end else begin
                drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
            end
            #1;
            checks++;
            if (a_gnt !== (i <= 9) || b_gnt !== (i >= 10)) begin
                errors++;
                $display("FAIL bp_cycle%0d a_gnt=%b b_gnt=%b required %b %b", i, a_gnt, b_gnt, (i <= 9), (i >= 10));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_early_release();
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hE0, 8'hF0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hE1, 8'hF1, 1'b1);
        sb_q.push_back({1'b1, 8'hE1});
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL er_grant_a a_gnt=%b required 1", a_gnt);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hE2, 8'hF2, 1'b1);
        #1;
        checks++;
        if (a_gnt !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL er_drop a_gnt=%b valid=%b required 1 0", a_gnt, out_valid);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hE3, 8'hF3, 1'b1);
        sb_q.push_back({1'b0, 8'hF3});
        #1;
        checks++;
        if (b_gnt !== 1'b1 || sel !== 1'b0) begin
            errors++;
            $display("FAIL er_grant_b b_gnt=%b sel=%b required 1 0", b_gnt, sel);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if ({busy, out_valid, a_gnt, b_gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL er_idle busy=%b valid=%b gnt=%b%b required 0 0 00", busy, out_valid, a_gnt, b_gnt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h66, 8'h77, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h66, 8'h77, 1'b0);
        #1;
        checks++;
        if (b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_grant_b b_gnt=%b required 1", b_gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_gnt, b_gnt, out_valid, sel, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL rm_async gnt=%b%b valid=%b sel=%b busy=%b required all 0",
                     a_gnt, b_gnt, out_valid, sel, busy);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h66, 8'h77, 1'b1);
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_release busy=%b required 0", busy);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h66, 8'h77, 1'b1);
        sb_q.push_back({1'b1, 8'h66});
        #1;
        checks++;
        if (a_gnt !== 1'b1 || sel !== 1'b1) begin
            errors++;
            $display("FAIL rm_a_pref a_gnt=%b sel=%b required 1 1", a_gnt, sel);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_idle busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_reset_mid();
        @(negedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_beats got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
